// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the memory bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    ERROR = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Wide all-ones constant; users slice off the byte lanes they need.
  localparam logic [127:0] FETCH_BE = '1;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : arb_watchdog
// Purpose : Counts waitrequest cycles of one bus access and raises a sticky
//           error when the count reaches LIMIT.
// Rev     : 1.0  initial release
// ============================================================================
module arb_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire,
  output logic error
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_error;

  // Fires during the LIMIT-th stalled cycle so the FSM leaves BUS on that edge.
  assign expire = count_en && (r_count == CNT_W'(LIMIT - 1));
  assign error  = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (count_en) begin
        r_count <= r_count + 1'b1;
      end
      if (expire) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one single-outstanding waitrequest memory bus between the
//           instruction-fetch and data load/store ports of the CPU core.
//           Optional waitrequest watchdog enabled by macro ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_address,
  output logic [DATA_W-1:0]   instr_readdata,
  output logic                instr_valid,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic [DATA_W-1:0]   data_writedata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                data_valid,
  output logic                stall,
  output logic [ADDR_W-1:0]   bus_address,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   bus_writedata,
  output logic [DATA_W/8-1:0] bus_byteenable,
  input  logic                bus_waitrequest,
  input  logic [DATA_W-1:0]   bus_readdata,
  output logic                bus_error
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_bus_read;
  logic              r_bus_write;
  logic              r_instr_valid;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_instr_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic w_data_req;
  logic w_pick_data;
  logic w_accept;
  logic w_timeout;
  logic w_err_stall;

  assign w_data_req  = data_read | data_write;
  assign w_pick_data = w_data_req & (~instr_req | (DATA_PRIORITY != 0));
  assign w_accept    = (r_bus_read | r_bus_write) & ~bus_waitrequest;

`ifdef ARB_TIMEOUT_EN
  logic w_wd_error;

  arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state == IDLE),
    .count_en ((r_state == BUS) & bus_waitrequest),
    .expire   (w_timeout),
    .error    (w_wd_error)
  );

  assign bus_error   = w_wd_error;
  assign w_err_stall = (r_state == ERROR);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
  assign bus_error        = 1'b0;
  assign w_err_stall      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner       <= OWN_INSTR;
      r_is_write    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_bus_read    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_instr_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_req | w_data_req) begin
            r_state <= BUS;
            if (w_pick_data) begin
              r_owner     <= OWN_DATA;
              r_is_write  <= data_write;
              r_addr      <= data_address;
              r_wdata     <= data_writedata;
              r_be        <= data_byteenable;
              r_bus_read  <= ~data_write;
              r_bus_write <= data_write;
            end else begin
              r_owner     <= OWN_INSTR;
              r_is_write  <= 1'b0;
              r_addr      <= instr_address;
              r_wdata     <= '0;
              r_be        <= FETCH_BE[BE_W-1:0];
              r_bus_read  <= 1'b1;
              r_bus_write <= 1'b0;
            end
          end
        end
        BUS: begin
          if (w_timeout) begin
            r_state     <= ERROR;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
          end else if (w_accept) begin
            r_state       <= RESP;
            r_bus_read    <= 1'b0;
            r_bus_write   <= 1'b0;
            r_instr_valid <= (r_owner == OWN_INSTR);
            r_data_valid  <= (r_owner == OWN_DATA);
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (!r_is_write) begin
            if (r_owner == OWN_DATA) begin
              r_data_rdata <= bus_readdata;
            end else begin
              r_instr_rdata <= bus_readdata;
            end
          end
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Read data only arrives during RESP, so it is bypassed while valid is high
  // and served from the holding register afterwards.
  assign instr_readdata = r_instr_valid ? bus_readdata : r_instr_rdata;
  assign data_readdata  = (r_data_valid && !r_is_write) ? bus_readdata : r_data_rdata;
  assign instr_valid    = r_instr_valid;
  assign data_valid     = r_data_valid;

  assign stall = (instr_req & ~r_instr_valid) | (w_data_req & ~r_data_valid) | w_err_stall;

  assign bus_address    = r_addr;
  assign bus_read       = r_bus_read;
  assign bus_write      = r_bus_write;
  assign bus_writedata  = r_wdata;
  assign bus_byteenable = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// Directed, table-driven bench for mem_bus_arbiter: one instance with data
// priority and one with instruction priority, each with its own memory model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0, data_read = 1'b0, data_write = 1'b0;
  logic [31:0] instr_address = '0, data_address = '0, data_writedata = '0;
  logic [3:0]  data_byteenable = '0;
  logic        bus_waitrequest = 1'b0;
  logic [31:0] bus_readdata, p0_bus_readdata;
  logic        p0_instr_req = 1'b0, p0_data_read = 1'b0, p0_data_write = 1'b0;

  logic [31:0] instr_readdata, data_readdata, bus_address, bus_writedata;
  logic        instr_valid, data_valid, stall, bus_read, bus_write, bus_error;
  logic [3:0]  bus_byteenable;
  logic [31:0] p0_instr_readdata, p0_data_readdata, p0_bus_address, p0_bus_writedata;
  logic        p0_instr_valid, p0_data_valid, p0_stall, p0_bus_read, p0_bus_write, p0_bus_error;
  logic [3:0]  p0_bus_byteenable;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_valid(instr_valid),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_valid(data_valid), .stall(stall),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
    .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata), .bus_error(bus_error)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_dut_p0 (
    .clk(clk), .reset(reset),
    .instr_req(p0_instr_req), .instr_address(instr_address),
    .instr_readdata(p0_instr_readdata), .instr_valid(p0_instr_valid),
    .data_read(p0_data_read), .data_write(p0_data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(p0_data_readdata), .data_valid(p0_data_valid), .stall(p0_stall),
    .bus_address(p0_bus_address), .bus_read(p0_bus_read), .bus_write(p0_bus_write),
    .bus_writedata(p0_bus_writedata), .bus_byteenable(p0_bus_byteenable),
    .bus_waitrequest(bus_waitrequest), .bus_readdata(p0_bus_readdata), .bus_error(p0_bus_error)
  );

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h2402_0005;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory returns data only in the cycle after an accepted read; garbage otherwise.
  always @(posedge clk) begin
    bus_readdata    <= (bus_read && !bus_waitrequest) ? mem_func(bus_address) : 32'hDEAD_BEEF;
    p0_bus_readdata <= (p0_bus_read && !bus_waitrequest) ? mem_func(p0_bus_address) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        is_data;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic        exp_write;
  } vec_t;

  vec_t vecs[6];

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    instr_req       = !v.is_data;
    data_read       = v.is_data & v.rd;
    data_write      = v.is_data & v.wr;
    instr_address   = v.addr;
    data_address    = v.addr;
    data_writedata  = v.wdata;
    data_byteenable = v.be;
    bus_waitrequest = 1'b0;
    settle();
    check({tag, " idle strobes"}, 64'({bus_read, bus_write}), 64'(2'b00));
    check({tag, " idle stall"}, 64'(stall), 64'(1'b1));
    next();
    for (int k = 0; k <= v.waits; k++) begin
      bus_waitrequest = (k < v.waits);
      settle();
      check({tag, " bus cmd"}, 64'({bus_read, bus_write, bus_address, bus_byteenable}),
            64'({~v.exp_write, v.exp_write, v.addr, v.exp_be}));
      if (v.exp_write) check({tag, " bus wdata"}, 64'(bus_writedata), 64'(v.wdata));
      check({tag, " no early valid"}, 64'({instr_valid, data_valid}), 64'(2'b00));
      // Disturb the requester operands; the latched copies must not follow.
      instr_address   = ~v.addr;
      data_address    = ~v.addr;
      data_writedata  = ~v.wdata;
      data_byteenable = ~v.be;
      next();
    end
    bus_waitrequest = 1'b0;
    settle();
    check({tag, " resp valid"}, 64'({instr_valid, data_valid}), v.is_data ? 64'(2'b01) : 64'(2'b10));
    check({tag, " resp rdata"}, 64'(v.is_data ? data_readdata : instr_readdata), 64'(v.exp_rdata));
    check({tag, " resp strobes"}, 64'({bus_read, bus_write, stall}), 64'(3'b000));
    next();
    instr_req  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    settle();
    check({tag, " post valid"}, 64'({instr_valid, data_valid}), 64'(2'b00));
    check({tag, " post rdata"}, 64'(v.is_data ? data_readdata : instr_readdata), 64'(v.exp_rdata));
  endtask

  initial begin
    //            is_d  rd    wr    addr           wdata          be    w  exp_rdata      exp_be exp_wr
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 32'h2402_0005, 4'hF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1, 32'h5A5A_0100, 4'hF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'h3, 3, 32'h5A5A_0100, 4'h3, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 2, 32'hDA5A_0010, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'hC, 0, 32'h5A5A_0100, 4'hC, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h8, 0, 32'hA5A5_FFFC, 4'h8, 1'b0};

    // Reset state
    next(); next(); next();
    settle();
    check("reset strobes", 64'({bus_read, bus_write, instr_valid, data_valid, stall, bus_error}), 64'(6'b0));
    check("reset rdata", 64'({instr_readdata, data_readdata}), 64'(0));
    reset = 1'b0;
    next();

    // Simultaneous requests: data first with priority 1, fetch first with priority 0
    instr_req = 1'b1; data_read = 1'b1; p0_instr_req = 1'b1; p0_data_read = 1'b1;
    instr_address = 32'h40; data_address = 32'h80; data_byteenable = 4'hF;
    next(); settle();
    check("prio1 first", 64'({bus_read, bus_address}), 64'({1'b1, 32'h80}));
    check("prio0 first", 64'({p0_bus_read, p0_bus_address}), 64'({1'b1, 32'h40}));
    next(); settle();
    check("prio1 first resp", 64'({instr_valid, data_valid, data_readdata}), 64'({2'b01, 32'h5A5A_0080}));
    check("prio0 first resp", 64'({p0_instr_valid, p0_data_valid, p0_instr_readdata}), 64'({2'b10, 32'h5A5A_0040}));
    next();
    data_read = 1'b0; p0_instr_req = 1'b0;
    settle();
    check("loser still stalled", 64'({stall, p0_stall, bus_read, p0_bus_read}), 64'(4'b1100));
    next(); settle();
    check("prio1 second", 64'({bus_read, bus_address}), 64'({1'b1, 32'h40}));
    check("prio0 second", 64'({p0_bus_read, p0_bus_address}), 64'({1'b1, 32'h80}));
    next(); settle();
    check("prio1 second resp", 64'({instr_valid, data_valid, instr_readdata}), 64'({2'b10, 32'h5A5A_0040}));
    check("prio0 second resp", 64'({p0_instr_valid, p0_data_valid, p0_data_readdata}), 64'({2'b01, 32'h5A5A_0080}));
    next();
    instr_req = 1'b0; p0_data_read = 1'b0;
    next();

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end
    check("instr rdata hold", 64'(instr_readdata), 64'(32'hDA5A_0010));
    check("data rdata after load", 64'(data_readdata), 64'(32'hA5A5_FFFC));

    // Request dropped after grant still completes with a valid pulse
    instr_req = 1'b1; instr_address = 32'h44;
    next(); settle();
    check("drop bus", 64'({bus_read, bus_address}), 64'({1'b1, 32'h44}));
    instr_req = 1'b0;
    settle();
    check("drop stall", 64'(stall), 64'(1'b0));
    next(); settle();
    check("drop resp", 64'({instr_valid, instr_readdata}), 64'({1'b1, 32'h5A5A_0044}));
    next();

    // Reset while on the bus abandons the access
    data_read = 1'b1; data_address = 32'h88;
    next(); settle();
    check("rst bus", 64'({bus_read, bus_address}), 64'({1'b1, 32'h88}));
    reset = 1'b1; data_read = 1'b0;
    next(); settle();
    check("rst strobes", 64'({bus_read, bus_write, instr_valid, data_valid}), 64'(4'b0));
    reset = 1'b0;
    next(); settle();
    check("rst no valid", 64'({bus_read, instr_valid, data_valid, stall}), 64'(4'b0));
    check("rst rdata ignored", 64'(data_readdata), 64'(0));
    next();

    // Waitrequest stuck high
    instr_req = 1'b1; instr_address = 32'h50; bus_waitrequest = 1'b1;
    next();
    for (int k = 1; k <= 12; k++) begin
      logic exp_err;
`ifdef ARB_TIMEOUT_EN
      exp_err = (k > 8);
`else
      exp_err = 1'b0;
`endif
      settle();
      check($sformatf("stuck c%0d", k), 64'({bus_error, bus_read, stall, instr_valid}),
            64'({exp_err, ~exp_err, 1'b1, 1'b0}));
      next();
    end
`ifdef ARB_TIMEOUT_EN
    instr_req = 1'b0; bus_waitrequest = 1'b0;
    settle();
    check("error stall held", 64'({bus_error, stall}), 64'(2'b11));
    reset = 1'b1;
    next();
    reset = 1'b0;
    settle();
    check("error cleared", 64'({bus_error, stall}), 64'(2'b00));
`else
    bus_waitrequest = 1'b0;
    next(); settle();
    check("stuck release", 64'({instr_valid, instr_readdata}), 64'({1'b1, 32'h5A5A_0050}));
    instr_req = 1'b0;
`endif
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
